// File: rtl/stream_upsizer.sv
// -----------------------------------------------------------------------------
// stream_upsizer
//   Valid/ready stream width converter. Packs up to RATIO narrow beats of DW
//   bits into one RATIO*DW-bit word with a per-lane keep mask and a last flag.
//   A beat carrying i_last, or the beat filling lane RATIO-1, closes the word.
//   The closed word is presented on registered outputs one cycle later.
//
// Parameters
//   DW           input beat width in bits
//   RATIO        beats per output word (power of two, >= 2)
//   OPT_LOWPOWER 1: lanes that were never filled are driven to zero in o_data
//
// Ports
//   i_clk, i_reset_n        clock, synchronous active-low reset
//   i_valid/o_ready/i_data/i_last   narrow upstream stream
//   o_valid/i_ready/o_data/o_keep/o_last   wide downstream stream
//   o_word_cnt              consumed-word counter (only with UPSIZER_CNT_EN)
//
// Optional feature macro: UPSIZER_CNT_EN
// -----------------------------------------------------------------------------
module stream_upsizer #(
  parameter int DW           = 8,
  parameter int RATIO        = 4,
  parameter int OPT_LOWPOWER = 0
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [DW-1:0]       i_data,
  input  logic                i_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [RATIO*DW-1:0] o_data,
  output logic [RATIO-1:0]    o_keep,
  output logic                o_last
`ifdef UPSIZER_CNT_EN
  ,
  output logic [31:0]         o_word_cnt
`endif
);

  localparam int LW = $clog2(RATIO);

  // Assembly state
  logic [RATIO*DW-1:0] asm_data_q, asm_data_d;
  logic [RATIO-1:0]    asm_keep_q, asm_keep_d;
  logic [LW-1:0]       lane_q, lane_d;

  // Output word registers
  logic [RATIO*DW-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0]    out_keep_q, out_keep_d;
  logic                out_last_q, out_last_d;
  logic                out_valid_q, out_valid_d;

  logic                accept;
  logic                consume;
  logic                closing;
  logic [RATIO*DW-1:0] merged_data;

  // Ready whenever the output register is empty or being drained this cycle.
  assign o_ready = !(out_valid_q && !i_ready);
  assign accept  = i_valid && o_ready;
  assign consume = out_valid_q && i_ready;
  assign closing = (lane_q == LW'(RATIO - 1)) || i_last;

  // Assembly contents merged with the current beat, so a closing beat lands in
  // the output register on the same edge it is accepted.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_merge
      logic keep_lane;
      assign keep_lane = asm_keep_q[gi] || (OPT_LOWPOWER == 0);
      assign merged_data[gi*DW +: DW] =
        (lane_q == LW'(gi)) ? i_data :
        keep_lane           ? asm_data_q[gi*DW +: DW] : '0;
    end
  endgenerate

  always_comb begin
    asm_data_d  = asm_data_q;
    asm_keep_d  = asm_keep_q;
    lane_d      = lane_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (closing) begin
        out_data_d  = merged_data;
        out_keep_d  = asm_keep_q | (RATIO'(1) << lane_q);
        out_last_d  = i_last;
        out_valid_d = 1'b1;
        lane_d      = '0;
        asm_keep_d  = '0;
      end else begin
        asm_data_d[lane_q*DW +: DW] = i_data;
        asm_keep_d[lane_q]          = 1'b1;
        lane_d                      = lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      asm_data_q  <= '0;
      asm_keep_q  <= '0;
      lane_q      <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      asm_data_q  <= asm_data_d;
      asm_keep_q  <= asm_keep_d;
      lane_q      <= lane_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;
  assign o_keep  = out_keep_q;
  assign o_last  = out_last_q;

`ifdef UPSIZER_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Wraps naturally from all-ones to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (consume) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_upsizer
//   Directed bench for stream_upsizer (DW=8, RATIO=4, OPT_LOWPOWER=1).
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_stream_upsizer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        ds_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
`ifdef UPSIZER_CNT_EN
  logic [31:0] word_cnt;
`endif

  int tests;
  int fails;

  stream_upsizer #(
    .DW(8),
    .RATIO(4),
    .OPT_LOWPOWER(1)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_valid   (in_valid),
    .o_ready   (out_ready),
    .i_data    (in_data),
    .i_last    (in_last),
    .o_valid   (out_valid),
    .i_ready   (ds_ready),
    .o_data    (out_data),
    .o_keep    (out_keep),
    .o_last    (out_last)
`ifdef UPSIZER_CNT_EN
    ,
    .o_word_cnt(word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                          input logic l);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".data"},  out_data, d);
    chk({tag, ".keep"},  {28'd0, out_keep}, {28'd0, k});
    chk({tag, ".last"},  {31'd0, out_last}, {31'd0, l});
    $display("[TB] %s: data=0x%08h keep=%b last=%0d", tag, out_data, out_keep, out_last);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset_n  = 1'b0;
    ds_ready = 1'b1;
    idle();

    // Reset state
    step();
    step();
    chk("reset.valid", {31'd0, out_valid}, 32'd0);
    chk("reset.keep",  {28'd0, out_keep}, 32'd0);
    chk("reset.last",  {31'd0, out_last}, 32'd0);
    chk("reset.data",  out_data, 32'd0);
    chk("reset.ready", {31'd0, out_ready}, 32'd1);
    reset_n = 1'b1;
    step();

    // Full word, valid for exactly one cycle
    beat(8'h11, 1'b0);
    chk("full.noearly", {31'd0, out_valid}, 32'd0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h44, 1'b1);
    idle();
    chk_word("full", 32'h44332211, 4'b1111, 1'b1);
    step();
    chk("full.onecycle", {31'd0, out_valid}, 32'd0);

    // Short packet, unfilled lanes zero
    beat(8'hA1, 1'b0);
    beat(8'hA2, 1'b1);
    idle();
    chk_word("short", 32'h0000A2A1, 4'b0011, 1'b1);
    step();

    // Back-pressure
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h44, 1'b1);
    ds_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b0;
    #1;
    chk("bp.ready0", {31'd0, out_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.hold.ready", {31'd0, out_ready}, 32'd0);
      chk("bp.hold.valid", {31'd0, out_valid}, 32'd1);
      chk("bp.hold.data",  out_data, 32'h44332211);
    end
    ds_ready = 1'b1;
    #1;
    chk("bp.release.ready", {31'd0, out_ready}, 32'd1);
    step();
    chk("bp.drained", {31'd0, out_valid}, 32'd0);
    beat(8'h66, 1'b1);
    idle();
    chk_word("bp.next", 32'h00006655, 4'b0011, 1'b1);
    step();

    // Multi-word packet
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b0);
    chk_word("multi.w1", 32'h04030201, 4'b1111, 1'b0);
    beat(8'h05, 1'b0);
    chk("multi.gap", {31'd0, out_valid}, 32'd0);
    beat(8'h06, 1'b1);
    idle();
    chk_word("multi.w2", 32'h00000605, 4'b0011, 1'b1);
    step();

    // Back-to-back single-beat packets: consume and load on the same edge
    beat(8'h77, 1'b1);
    chk_word("b2b.w1", 32'h00000077, 4'b0001, 1'b1);
    beat(8'h88, 1'b1);
    idle();
    chk_word("b2b.w2", 32'h00000088, 4'b0001, 1'b1);
    step();

    // Reset mid-packet
    beat(8'hC1, 1'b0);
    beat(8'hC2, 1'b0);
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rstmid.valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid.keep",  {28'd0, out_keep}, 32'd0);
    beat(8'hB1, 1'b0);
    beat(8'hB2, 1'b0);
    beat(8'hB3, 1'b0);
    beat(8'hB4, 1'b1);
    idle();
    chk_word("rstmid", 32'hB4B3B2B1, 4'b1111, 1'b1);
    step();

    // Three words consumed, a fourth held
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    beat(8'hD1, 1'b1);
    beat(8'hD2, 1'b1);
    beat(8'hD3, 1'b1);
    idle();
    step();
    ds_ready = 1'b0;
    beat(8'hE1, 1'b1);
    idle();
    step();
    chk_word("held", 32'h000000E1, 4'b0001, 1'b1);
`ifdef UPSIZER_CNT_EN
    chk("cnt", word_cnt, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Valid/ready stream width converter. Packs RATIO narrow beats of DW bits into one output word of RATIO*DW bits, with a per-lane keep mask and a last flag.
- Sits directly upstream of the skidbuffer in the PCIe datapath. The skidbuffer takes this block's registered output and breaks the i_ready -> o_ready combinational path.
- Packet boundaries (i_last) force early emission of a partially filled word.

Parameters:
- DW, 8, input beat width in bits.
- RATIO, 4, beats per output word; power of two, >= 2.
- OPT_LOWPOWER, 0, when 1, unfilled lanes of o_data are driven to zero.

Ports:
- i_clk  input  1  clock
- i_reset_n  input  1  synchronous, active-low reset
- i_valid  input  1  upstream beat valid
- o_ready  output  1  block can accept a beat this cycle
- i_data  input  DW  upstream beat data
- i_last  input  1  beat is the final beat of a packet
- o_valid  output  1  packed word valid
- i_ready  input  1  downstream accepts the word
- o_data  output  RATIO*DW  packed word; beat k occupies bits [k*DW +: DW], little-endian
- o_keep  output  RATIO  bit k = 1 when lane k holds a valid beat
- o_last  output  1  word closes a packet

Behaviour:
- Interface: one clock; reset is synchronous and active-low (i_clk, i_reset_n).
- Reset (i_reset_n = 0 at a rising edge) clears o_valid, o_last, o_keep, the assembly lane counter and the assembly keep mask. o_data is cleared to 0.
  - Reset has priority over every other event, including a handshake in the same cycle.
  - Partial assembly is discarded mid-packet.
- Handshake rules:
  - o_ready = !(o_valid && !i_ready), combinational.
  - An input beat is accepted when i_valid && o_ready.
  - An output word is consumed when o_valid && i_ready.
- Internal state:
  - Assembly register asm_data (RATIO*DW).
  - asm_keep (RATIO bits).
  - lane counter lane (clog2(RATIO) bits, 0..RATIO-1).
- Accepted beat, non-closing (lane != RATIO-1 and !i_last):
  - i_data is written to lane `lane`; asm_keep[lane] is set; lane increments.
  - o_valid is unchanged, except that a consumed word drops o_valid to 0.
- Accepted beat, closing (lane == RATIO-1 or i_last):
  - The output register loads the assembly contents merged with the current beat, on the same edge.
  - o_keep = asm_keep | (1 << lane); o_last = i_last; o_valid = 1.
  - Assembly clears: lane = 0, asm_keep = 0.
  - Latency: input closing beat to o_valid is exactly 1 cycle.
- Unfilled lanes:
  - OPT_LOWPOWER = 1: unfilled lanes of o_data are 0.
  - OPT_LOWPOWER = 0: unfilled lanes may hold stale data; the bench checks them only under o_keep.
- Lane wrap: lane RATIO-1 always closes the word. A beat with i_last at lane RATIO-1 yields o_keep all ones and o_last = 1.
- Simultaneous accept and consume (o_valid && i_ready && closing beat): old word leaves and new word loads on the same edge; no bubble.
- Word held: while o_valid && !i_ready, o_data, o_keep and o_last are stable and no beat is accepted.
- Throughput: one beat per cycle when downstream is always ready.
- Empty packet: not supported. Every packet has at least one beat.

Optional Feature:
- Macro: UPSIZER_CNT_EN.
- With the macro defined:
  - Adds output port o_word_cnt (32 bits): count of consumed output words.
  - Increments by 1 on each o_valid && i_ready; wraps 0xFFFFFFFF -> 0.
  - Cleared by reset.
- Without the macro: the port and counter do not exist; behaviour is otherwise identical.

Test Plan (DW=8, RATIO=4):
- Full word: i_ready = 1; beats 0x11,0x22,0x33,0x44, i_last on 0x44 -> 1 cycle after the 4th beat: o_data = 0x44332211, o_keep = 4'b1111, o_last = 1, o_valid for exactly 1 cycle.
- Short packet: beats 0xA1,0xA2 with i_last on 0xA2, OPT_LOWPOWER = 1 -> o_data = 0x0000A2A1, o_keep = 4'b0011, o_last = 1.
- Back-pressure: i_ready = 0 while word 0x44332211 is pending, upstream beat 0x55 valid -> o_ready = 0 and o_data stable for 5 cycles. After i_ready = 1: 0x55 is accepted the same cycle and lands in lane 0 of the next word.
- Multi-word packet: 6 beats 0x01..0x06, last on 0x06 -> word 1 = 0x04030201, keep 1111, last 0; word 2 keep 0011 with lanes 0x05,0x06, last 1.
- Reset mid-packet: 2 beats accepted, then i_reset_n = 0 for 1 cycle -> o_valid = 0 and the next 4 beats 0xB1..0xB4 produce 0xB4B3B2B1 with keep 1111.
- UPSIZER_CNT_EN: 3 words consumed, 1 held unconsumed -> o_word_cnt = 3.
